mdu: RTL and testbench



---
 rtl/mdu.sv | 140 ++++++++++++++
 tb/tb_mdu.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mdu.sv
// Multiply/divide unit for the E stage: multi-cycle mult/multu/div/divu into HI/LO,
// single-cycle mthi/mtlo, with busy/stall outputs for the hazard unit.
module mdu #(
    parameter int WIDTH       = 32,
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             stall_req,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW         = $clog2(MAX_CYCLES + 1);
    localparam logic [CW-1:0] MULT_LAT = CW'(MULT_CYCLES);
    localparam logic [CW-1:0] DIV_LAT  = CW'(DIV_CYCLES);

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;

    typedef enum logic {S_IDLE, S_RUN} state_t;

    state_t           r_state;
    logic [CW-1:0]    r_cnt;
    logic [2:0]       r_op;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic             r_busy;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;

    // Sign-extending to 2*WIDTH lets one unsigned multiplier yield the exact signed product.
    logic [2*WIDTH-1:0] w_prod_s;
    logic [2*WIDTH-1:0] w_prod_u;
    assign w_prod_s = {{WIDTH{r_a[WIDTH-1]}}, r_a} * {{WIDTH{r_b[WIDTH-1]}}, r_b};
    assign w_prod_u = {{WIDTH{1'b0}}, r_a} * {{WIDTH{1'b0}}, r_b};

    // Divide on magnitudes, then restore signs; min/-1 falls out as LO=min, HI=0.
    logic             w_sdiv;
    logic             w_a_neg;
    logic             w_b_neg;
    logic [WIDTH-1:0] w_dvd;
    logic [WIDTH-1:0] w_dvs;
    logic [WIDTH-1:0] w_q_mag;
    logic [WIDTH-1:0] w_r_mag;
    logic [WIDTH-1:0] w_quot;
    logic [WIDTH-1:0] w_rem;
    assign w_sdiv  = (r_op == OP_DIV);
    assign w_a_neg = w_sdiv & r_a[WIDTH-1];
    assign w_b_neg = w_sdiv & r_b[WIDTH-1];
    assign w_dvd   = w_a_neg ? -r_a : r_a;
    assign w_dvs   = (r_b == '0) ? WIDTH'(1) : (w_b_neg ? -r_b : r_b);
    assign w_q_mag = w_dvd / w_dvs;
    assign w_r_mag = w_dvd % w_dvs;
    assign w_quot  = (w_a_neg ^ w_b_neg) ? -w_q_mag : w_q_mag;
    assign w_rem   = w_a_neg ? -w_r_mag : w_r_mag;

    logic [WIDTH-1:0] w_hi;
    logic [WIDTH-1:0] w_lo;
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        w_hi = '0;
        w_lo = '0;
        case (r_op)
            OP_MULT:  {w_hi, w_lo} = w_prod_s;
            OP_MULTU: {w_hi, w_lo} = w_prod_u;
            OP_DIV, OP_DIVU: begin
                if (r_b == '0) begin
                    w_lo = '1;
                    w_hi = r_a;
                end else begin
                    w_lo = w_quot;
                    w_hi = w_rem;
                end
            end
            default: ;
        endcase
    end

    // NOTE: state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_op    <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_busy  <= 1'b0;
            r_hi    <= '0;
            r_lo    <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        case (op)
                            OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
                                r_op    <= op;
                                r_a     <= A;
                                r_b     <= B;
                                r_cnt   <= (op[1]) ? DIV_LAT : MULT_LAT;
                                r_busy  <= 1'b1;
                                r_state <= S_RUN;
                            end
                            OP_MTHI: r_hi <= A;
                            OP_MTLO: r_lo <= A;
                            default: ;
                        endcase
                    end
                end
                S_RUN: begin
                    r_cnt <= r_cnt - CW'(1);
                    if (r_cnt == CW'(1)) begin
                        r_hi    <= w_hi;
                        r_lo    <= w_lo;
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign busy      = r_busy;
    assign stall_req = r_busy | (start & (op <= OP_DIVU));
    assign HI        = r_hi;
    assign LO        = r_lo;

endmodule

// File: tb/tb_mdu.sv
// Directed bench for mdu: a 32-bit instance (5/10 cycles) with vector table and corner sequences,
// and an 8-bit instance (1/3 cycles) swept over corner operands against a behavioural model.
module tb_mdu;

    localparam int MC  = 5;
    localparam int DC  = 10;
    localparam int MC8 = 1;
    localparam int DC8 = 3;

    logic clk = 1'b0;
    logic reset = 1'b1;

    logic        start0 = 1'b0;
    logic [2:0]  op0 = '0;
    logic [31:0] a0 = '0;
    logic [31:0] b0 = '0;
    logic        busy0, stall0;
    logic [31:0] hi0, lo0;

    logic        start1 = 1'b0;
    logic [2:0]  op1 = '0;
    logic [7:0]  a1 = '0;
    logic [7:0]  b1 = '0;
    logic        busy1, stall1;
    logic [7:0]  hi1, lo1;

    int n_vec  = 0;
    int n_fail = 0;

    mdu #(.WIDTH(32), .MULT_CYCLES(MC), .DIV_CYCLES(DC)) u_dut32 (
        .clk(clk), .reset(reset), .start(start0), .op(op0), .A(a0), .B(b0),
        .busy(busy0), .stall_req(stall0), .HI(hi0), .LO(lo0)
    );

    mdu #(.WIDTH(8), .MULT_CYCLES(MC8), .DIV_CYCLES(DC8)) u_dut8 (
        .clk(clk), .reset(reset), .start(start1), .op(op1), .A(a1), .B(b1),
        .busy(busy1), .stall_req(stall1), .HI(hi1), .LO(lo1)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
    } vec_t;

    vec_t vecs[13];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one op on the 32-bit DUT, scramble A/B (and optionally poke start) while busy.
    task automatic run0(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] ehi, input logic [31:0] elo,
                        input string tag, input bit poke);
        int n;
        int exp_n;
        exp_n = (op < 3'd2) ? MC : DC;
        start0 = 1'b1; op0 = op; a0 = a; b0 = b;
        #1;
        check($sformatf("%s_stall_issue", tag), stall0, 1);
        tick();
        n = 0;
        while (busy0 && n < 200) begin
            n++;
            a0 = $urandom;
            b0 = $urandom;
            if (poke) begin
                start0 = 1'b1;
                op0 = 3'($urandom_range(0, 5));
            end else begin
                start0 = 1'b0;
            end
            tick();
        end
        start0 = 1'b0;
        check($sformatf("%s_busy_cycles", tag), n, exp_n);
        check($sformatf("%s_hi", tag), hi0, ehi);
        check($sformatf("%s_lo", tag), lo0, elo);
        #1;
        check($sformatf("%s_stall_after", tag), stall0, 0);
    endtask

    task automatic model8(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                          output logic [7:0] hi, output logic [7:0] lo);
        longint sa, sb, ua, ub, p, q, r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'({56'd0, a});
        ub = longint'({56'd0, b});
        hi = '0;
        lo = '0;
        case (op)
            3'd0: begin p = sa * sb; hi = p[15:8]; lo = p[7:0]; end
            3'd1: begin p = ua * ub; hi = p[15:8]; lo = p[7:0]; end
            3'd2, 3'd3: begin
                if (b == 8'd0) begin
                    lo = 8'hFF;
                    hi = a;
                end else begin
                    if (op == 3'd2) begin q = sa / sb; r = sa % sb; end
                    else begin q = ua / ub; r = ua % ub; end
                    lo = q[7:0];
                    hi = r[7:0];
                end
            end
            default: ;
        endcase
    endtask

    task automatic run1(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        int n;
        int exp_n;
        logic [7:0] ehi, elo;
        model8(op, a, b, ehi, elo);
        exp_n = (op < 3'd2) ? MC8 : DC8;
        start1 = 1'b1; op1 = op; a1 = a; b1 = b;
        tick();
        start1 = 1'b0;
        n = 0;
        while (busy1 && n < 100) begin
            n++;
            a1 = 8'($urandom);
            b1 = 8'($urandom);
            tick();
        end
        check($sformatf("w8_op%0d_%0h_%0h_busy", op, a, b), n, exp_n);
        check($sformatf("w8_op%0d_%0h_%0h_hi", op, a, b), hi1, ehi);
        check($sformatf("w8_op%0d_%0h_%0h_lo", op, a, b), lo1, elo);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] cv[6];
        int wait_n;

        vecs[0]  = '{3'd0, 32'hFFFFFFFE, 32'd3,        32'hFFFFFFFF, 32'hFFFFFFFA};
        vecs[1]  = '{3'd1, 32'hFFFFFFFE, 32'd3,        32'h00000002, 32'hFFFFFFFA};
        vecs[2]  = '{3'd2, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD};
        vecs[3]  = '{3'd3, 32'd7,        32'd2,        32'd1,        32'd3};
        vecs[4]  = '{3'd2, 32'h00001234, 32'd0,        32'h00001234, 32'hFFFFFFFF};
        vecs[5]  = '{3'd2, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
        vecs[6]  = '{3'd3, 32'h00001234, 32'd0,        32'h00001234, 32'hFFFFFFFF};
        vecs[7]  = '{3'd0, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h3FFFFFFF, 32'h00000001};
        vecs[8]  = '{3'd0, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
        vecs[9]  = '{3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
        vecs[10] = '{3'd2, 32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD};
        vecs[11] = '{3'd3, 32'hFFFFFFF9, 32'd2,        32'd1,        32'h7FFFFFFC};
        vecs[12] = '{3'd2, 32'hFFFFFFF8, 32'hFFFFFFFD, 32'hFFFFFFFE, 32'd2};

        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        check("reset_busy", busy0, 0);
        check("reset_stall", stall0, 0);
        check("reset_hi", hi0, 0);
        check("reset_lo", lo0, 0);
        check("reset_busy_w8", busy1, 0);

        for (int i = 0; i < 13; i++) begin
            run0(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].hi, vecs[i].lo,
                 $sformatf("v%0d", i), (i % 2) == 1);
        end

        // mthi then mtlo on consecutive edges, then reserved ops.
        start0 = 1'b1; op0 = 3'd4; a0 = 32'hAAAA5555;
        #1;
        check("mthi_stall", stall0, 0);
        tick();
        check("mthi_hi", hi0, 32'hAAAA5555);
        check("mthi_busy", busy0, 0);
        op0 = 3'd5; a0 = 32'h5555AAAA;
        #1;
        check("mtlo_stall", stall0, 0);
        tick();
        check("mtlo_lo", lo0, 32'h5555AAAA);
        check("mtlo_hi_kept", hi0, 32'hAAAA5555);
        check("mtlo_busy", busy0, 0);
        op0 = 3'd6; a0 = 32'h0; b0 = 32'h0;
        #1;
        check("op6_stall", stall0, 0);
        tick();
        op0 = 3'd7;
        tick();
        start0 = 1'b0;
        check("op67_hi", hi0, 32'hAAAA5555);
        check("op67_lo", lo0, 32'h5555AAAA);
        check("op67_busy", busy0, 0);

        // Reset during the third cycle of a mult aborts it.
        start0 = 1'b1; op0 = 3'd0; a0 = 32'd3; b0 = 32'd4;
        tick();
        start0 = 1'b0;
        tick();
        tick();
        check("midrun_busy_before", busy0, 1);
        reset = 1'b1;
        tick();
        check("midrun_busy", busy0, 0);
        check("midrun_hi", hi0, 0);
        check("midrun_lo", lo0, 0);
        reset = 1'b0;
        for (int i = 0; i < MC + 1; i++) tick();
        check("midrun_no_resume_lo", lo0, 0);

        // Back-to-back: second op issued in the first cycle with busy low.
        start0 = 1'b1; op0 = 3'd0; a0 = 32'd3; b0 = 32'd4;
        tick();
        start0 = 1'b0;
        wait_n = 0;
        while (busy0 && wait_n < 100) begin wait_n++; tick(); end
        check("b2b_first_cycles", wait_n, MC);
        check("b2b_first_lo", lo0, 32'd12);
        start0 = 1'b1; op0 = 3'd1; a0 = 32'd5; b0 = 32'd6;
        #1;
        check("b2b_stall_issue", stall0, 1);
        tick();
        start0 = 1'b0;
        check("b2b_accepted", busy0, 1);
        wait_n = 0;
        while (busy0 && wait_n < 100) begin wait_n++; tick(); end
        check("b2b_second_cycles", wait_n, MC);
        check("b2b_second_lo", lo0, 32'd30);
        check("b2b_second_hi", hi0, 32'd0);

        // 8-bit instance: corner operand sweep plus a few random pairs.
        cv[0] = 8'h00; cv[1] = 8'h01; cv[2] = 8'hFF;
        cv[3] = 8'h80; cv[4] = 8'h7F; cv[5] = 8'h05;
        for (int o = 0; o < 4; o++) begin
            for (int i = 0; i < 6; i++) begin
                for (int j = 0; j < 6; j++) begin
                    run1(3'(o), cv[i], cv[j]);
                end
            end
        end
        for (int k = 0; k < 24; k++) begin
            run1(3'(k % 4), 8'($urandom), 8'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
